// File: rtl/write_mem_stage_pkg.sv
// Shared types for the write-memory pipeline stage.
//   InsnBundle : instruction bundle carried between pipeline stages
//   StoreEntry : one store queue slot (word address, data, byte enables)
//   SqState    : store-side fence sequencing state
package write_mem_stage_pkg;

    // Widest word address supported (32-bit byte address, word granular).
    localparam int SQ_ADDR_W_MAX = 30;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        valid;
    } InsnBundle;

    typedef struct packed {
        logic [SQ_ADDR_W_MAX-1:0] addr;
        logic [31:0]              data;
        logic [3:0]               be;
    } StoreEntry;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FENCE = 2'd1,
        DONE  = 2'd2
    } SqState;

endpackage

// File: rtl/write_mem_stage_store_queue.sv
// In-order store queue with a read-after-write forwarding CAM.
//   push/push_*  : enqueue at tail (caller guarantees !full)
//   pop          : dequeue head (caller guarantees !empty)
//   head_*       : head entry, drives the memory write port
//   full/empty   : occupancy flags from the wrap-bit pointers
//   fwd_addr     : load word address to look up
//   fwd_hit/data/be : youngest matching entry, zero when nothing matches
module write_mem_stage_store_queue
    import write_mem_stage_pkg::*;
#(
    parameter int AW    = 30,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [31:0]   push_data,
    input  logic [3:0]    push_be,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_addr,
    output logic [31:0]   head_data,
    output logic [3:0]    head_be,
    input  logic [AW-1:0] fwd_addr,
    output logic          fwd_hit,
    output logic [31:0]   fwd_data,
    output logic [3:0]    fwd_be
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [DEPTH-1:0] ent_vld;
    StoreEntry        mem [DEPTH];
    StoreEntry        wr_entry;
    StoreEntry        head_e;
    logic [PW-1:0]    idx;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    always_comb begin
        wr_entry              = '0;
        wr_entry.addr[AW-1:0] = push_addr;
        wr_entry.data         = push_data;
        wr_entry.be           = push_be;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ent_vld <= '0;
        end else begin
            if (push) begin
                ent_vld[wr_ptr[PW-1:0]] <= 1'b1;
                wr_ptr                  <= wr_ptr + (PW+1)'(1);
            end
            if (pop) begin
                ent_vld[rd_ptr[PW-1:0]] <= 1'b0;
                rd_ptr                  <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    // Payload storage is not reset; ent_vld qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= wr_entry;
        end
    end

    assign head_e    = mem[rd_ptr[PW-1:0]];
    assign head_addr = head_e.addr[AW-1:0];
    assign head_data = head_e.data;
    assign head_be   = head_e.be;

    // Walk from head (oldest) toward tail so a later match overrides an
    // earlier one: the youngest matching store wins. The head entry stays
    // valid until the clock edge that pops it, so it still forwards then.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_be   = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr[PW-1:0] + PW'(i);
            if (ent_vld[idx] && (mem[idx].addr[AW-1:0] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem[idx].data;
                fwd_be   = mem[idx].be;
            end
        end
    end

endmodule

// File: rtl/write_mem_stage.sv
// Write-memory pipeline stage: buffers stores in an in-order queue, drains
// them to the data memory write port, forwards queued data to loads and
// passes every instruction bundle on with one cycle of latency.
//   insn / stage_out_insn : bundle in, registered bundle out
//   st_valid/st_ready     : store handshake (st_addr, st_data, st_be)
//   fence_req/fence_done  : level request to drain; one-cycle completion pulse
//   mem_wr_*              : valid/ready write port fed from the queue head
//   fwd_addr/fwd_*        : read-after-write forwarding lookup
//   sq_empty              : queue holds no stores
module write_mem_stage
    import write_mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int SQ_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  InsnBundle             insn,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_WIDTH-3:0] st_addr,
    input  logic [31:0]           st_data,
    input  logic [3:0]            st_be,
    input  logic                  fence_req,
    output logic                  fence_done,
    output InsnBundle             stage_out_insn,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_WIDTH-3:0] mem_wr_addr,
    output logic [31:0]           mem_wr_data,
    output logic [3:0]            mem_wr_be,
    input  logic [ADDR_WIDTH-3:0] fwd_addr,
    output logic                  fwd_hit,
    output logic [31:0]           fwd_data,
    output logic [3:0]            fwd_be,
    output logic                  sq_empty
);

    localparam int AW = ADDR_WIDTH - 2;

    SqState state;
    logic   sq_full;
    logic   push;
    logic   pop;

    // Accept only from registered state; a same-cycle pop does not open a
    // slot in a full queue. Held low while reset is asserted.
    assign st_ready     = !rst && (state == RUN) && !sq_full;
    assign mem_wr_valid = !rst && !sq_empty;
    assign push         = st_valid && st_ready;
    assign pop          = mem_wr_valid && mem_wr_ready;
    assign fence_done   = (state == DONE);

    write_mem_stage_store_queue #(
        .AW    (AW),
        .DEPTH (SQ_DEPTH)
    ) u_sq (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (st_addr),
        .push_data (st_data),
        .push_be   (st_be),
        .pop       (pop),
        .full      (sq_full),
        .empty     (sq_empty),
        .head_addr (mem_wr_addr),
        .head_data (mem_wr_data),
        .head_be   (mem_wr_be),
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .fwd_be    (fwd_be)
    );

    // Fence sequencing: stop accepting, wait for the queue to drain, then
    // pulse completion for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (fence_req) state <= FENCE;
                FENCE:   if (sq_empty)  state <= DONE;
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Pipe register stage p0 -> next stage
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_out_insn <= '0;
        end else begin
            stage_out_insn <= insn;
        end
    end

endmodule

// File: tb/tb_write_mem_stage.sv
module tb_write_mem_stage;
    import write_mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    InsnBundle   insn;
    logic        st_valid;
    logic        st_ready;
    logic [29:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        fence_req;
    logic        fence_done;
    InsnBundle   stage_out_insn;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [29:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic [29:0] fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_be;
    logic        sq_empty;

    always #5 clk = ~clk;

    write_mem_stage #(.ADDR_WIDTH(32), .SQ_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .insn           (insn),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_be          (st_be),
        .fence_req      (fence_req),
        .fence_done     (fence_done),
        .stage_out_insn (stage_out_insn),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_ready   (mem_wr_ready),
        .mem_wr_addr    (mem_wr_addr),
        .mem_wr_data    (mem_wr_data),
        .mem_wr_be      (mem_wr_be),
        .fwd_addr       (fwd_addr),
        .fwd_hit        (fwd_hit),
        .fwd_data       (fwd_data),
        .fwd_be         (fwd_be),
        .sq_empty       (sq_empty)
    );

    // Reference model: the queue is a plain FIFO of stores, the fence is a
    // phase number (0 running, 1 draining, 2 completion cycle).
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t      q[$];
    int        phase;
    InsnBundle prev_insn;
    int        checks = 0;
    int        errors = 0;
    ent_t      drained[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the current cycle against the model, clocks once, updates model.
    task automatic step();
        logic exp_ready;
        logic do_push;
        logic do_pop;
        logic hit;
        ent_t fe;
        ent_t ne;
        #1;
        exp_ready = (rst == 1'b0) && (phase == 0) && (q.size() < 4);
        chk("st_ready", 128'(st_ready), 128'(exp_ready));
        if (rst) begin
            chk("rst_wr_valid", 128'(mem_wr_valid), 128'(0));
        end else begin
            chk("sq_empty", 128'(sq_empty), 128'(q.size() == 0));
            chk("wr_valid", 128'(mem_wr_valid), 128'(q.size() != 0));
            if (q.size() != 0) begin
                chk("wr_head", 128'({mem_wr_addr, mem_wr_data, mem_wr_be}), 128'(q[0]));
            end
            chk("fence_done", 128'(fence_done), 128'(phase == 2));
            chk("stage_out", 128'(stage_out_insn), 128'(prev_insn));
            hit = 1'b0;
            fe  = '0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!hit && q[i].addr == fwd_addr) begin
                    hit = 1'b1;
                    fe  = q[i];
                end
            end
            chk("fwd", 128'({fwd_hit, fwd_data, fwd_be}), 128'({hit, fe.data, fe.be}));
        end
        do_push = st_valid && exp_ready;
        do_pop  = mem_wr_ready && (q.size() != 0) && !rst;
        ne      = '{addr: st_addr, data: st_data, be: st_be};
        @(posedge clk);
        if (rst) begin
            q.delete();
            phase     = 0;
            prev_insn = '0;
        end else begin
            case (phase)
                0: if (fence_req) phase = 1;
                1: if (q.size() == 0) phase = 2;
                default: phase = 0;
            endcase
            if (do_pop) begin
                drained.push_back(q[0]);
                void'(q.pop_front());
            end
            if (do_push) q.push_back(ne);
            prev_insn = insn;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic wr, input logic f,
                         input logic [29:0] fa);
        st_valid     = v;
        st_addr      = a;
        st_data      = d;
        st_be        = be;
        mem_wr_ready = wr;
        fence_req    = f;
        fwd_addr     = fa;
        insn.pc      = $urandom;
        insn.instr   = $urandom;
        insn.rd      = 5'($urandom);
        insn.valid   = 1'($urandom);
        step();
    endtask

    initial begin
        int   pulses;
        logic seen;
        rst   = 1'b1;
        phase = 0;
        prev_insn = '0;
        insn  = '0;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = 4'hF;
        mem_wr_ready = 1'b0; fence_req = 1'b0; fwd_addr = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // 1: idle after reset
        step();
        chk("t1_empty", 128'(sq_empty), 128'(1));
        chk("t1_ready", 128'(st_ready), 128'(1));

        // 2: single store drains
        drive(1, 30'h10, 32'hDEADBEEF, 4'hF, 1, 0, 30'h0);
        chk("t2_valid", 128'(mem_wr_valid), 128'(1));
        chk("t2_addr", 128'(mem_wr_addr), 128'(30'h10));
        drive(0, 30'h0, 32'h0, 4'hF, 1, 0, 30'h0);
        chk("t2_empty_after", 128'(sq_empty), 128'(1));

        // 3: fill with memory stalled, stall the fifth, then drain in order
        for (int i = 0; i < 4; i++) drive(1, 30'h30 + 30'(i), 32'hA000 + 32'(i), 4'hF, 0, 0, 30'h0);
        chk("t3_full_stall", 128'(st_ready), 128'(0));
        drive(1, 30'h3F, 32'hBAD, 4'hF, 0, 0, 30'h0);
        drained.delete();
        for (int i = 0; i < 5; i++) drive(0, 30'h0, 32'h0, 4'hF, 1, 0, 30'h0);
        chk("t3_drain_count", 128'(drained.size()), 128'(4));
        chk("t3_drain_last", 128'(drained[drained.size()-1].addr), 128'(30'h33));

        // 4: youngest match forwards
        drive(1, 30'h20, 32'h11111111, 4'hF, 0, 0, 30'h0);
        drive(1, 30'h20, 32'h22222222, 4'h3, 0, 0, 30'h0);
        fwd_addr = 30'h20;
        #1;
        chk("t4_fwd", 128'({fwd_hit, fwd_data, fwd_be}), 128'({1'b1, 32'h22222222, 4'h3}));
        for (int i = 0; i < 3; i++) drive(0, 30'h0, 32'h0, 4'hF, 1, 0, 30'h20);

        // 5: steady enqueue + dequeue at depth two
        drive(1, 30'h40, 32'h500, 4'hF, 0, 0, 30'h0);
        drive(1, 30'h41, 32'h501, 4'hF, 0, 0, 30'h0);
        for (int i = 0; i < 10; i++) drive(1, 30'h42 + 30'(i), 32'h502 + 32'(i), 4'h1, 1, 0, 30'h41);
        drive(0, 30'h0, 32'h0, 4'hF, 1, 0, 30'h0);
        chk("t5_one_left", 128'(sq_empty), 128'(0));
        drive(0, 30'h0, 32'h0, 4'hF, 1, 0, 30'h0);
        chk("t5_drained", 128'(sq_empty), 128'(1));

        // 6: fence with three queued stores
        for (int i = 0; i < 3; i++) drive(1, 30'h50 + 30'(i), 32'h600 + 32'(i), 4'hF, 0, 0, 30'h0);
        drive(1, 30'h5F, 32'h6FF, 4'hF, 0, 1, 30'h0);
        chk("t6_blocked", 128'(st_ready), 128'(0));
        seen = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            drive(1, 30'h5E, 32'h6EE, 4'hF, 1, 1, 30'h0);
            if (fence_done) seen = 1'b1;
        end
        chk("t6_fence_timeout", 128'(seen), 128'(1));
        for (int k = 0; k < 4; k++) begin
            if (fence_done) pulses++;
            drive(0, 30'h0, 32'h0, 4'hF, 1, 0, 30'h0);
        end
        chk("t6_single_pulse", 128'(pulses), 128'(1));
        chk("t6_ready_again", 128'(st_ready), 128'(1));

        // fence on an empty queue
        drive(0, 30'h0, 32'h0, 4'hF, 1, 1, 30'h0);
        drive(0, 30'h0, 32'h0, 4'hF, 1, 0, 30'h0);
        chk("empty_fence_done", 128'(fence_done), 128'(1));
        drive(0, 30'h0, 32'h0, 4'hF, 1, 0, 30'h0);

        // randomized traffic, with one reset in the middle
        for (int k = 0; k < 400; k++) begin
            if (k == 200) begin
                rst = 1'b1;
                drive(1, 30'h1, 32'h1, 4'hF, 0, 0, 30'h1);
                rst = 1'b0;
            end
            drive(1'($urandom_range(0, 1)), 30'($urandom_range(0, 5)), $urandom,
                  4'($urandom_range(1, 15)), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 39) == 0), 30'($urandom_range(0, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
